// File: rtl/mlp_seq.sv
// mlp_seq: two-layer MLP evaluated neuron by neuron on one shared signed MAC, behind a simple register port.
// Define MLP_SEQ_SAT_EN to saturate activations; by default they wrap to OUT_WIDTH bits.
module mlp_seq #(
    parameter int N_INPUTS  = 2,
    parameter int N_HIDDEN  = 4,
    parameter int N_OUTPUT  = 1,
    parameter int IN_WIDTH  = 16,
    parameter int WGT_WIDTH = 16,
    parameter int MAC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic [2:0]  addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int CW      = 16;
    localparam int PW      = IN_WIDTH + WGT_WIDTH;
    localparam int W1_SIZE = N_HIDDEN * (N_INPUTS + 1);
    localparam int W2_SIZE = N_OUTPUT * (N_HIDDEN + 1);
    localparam int XW      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int HW      = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam int YW      = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
    localparam int W1_AW   = (W1_SIZE > 1) ? $clog2(W1_SIZE) : 1;
    localparam int W2_AW   = (W2_SIZE > 1) ? $clog2(W2_SIZE) : 1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_INPUT  = 3'd1;
    localparam logic [2:0] A_WADDR  = 3'd2;
    localparam logic [2:0] A_WDATA  = 3'd3;
    localparam logic [2:0] A_OUTSEL = 3'd4;
    localparam logic [2:0] A_OUTPUT = 3'd5;
    localparam logic [2:0] A_CYCLES = 3'd6;
    localparam logic [2:0] A_STATUS = 3'd7;

    localparam logic [CW-1:0] L0_K_LAST = CW'(N_INPUTS);
    localparam logic [CW-1:0] L1_K_LAST = CW'(N_HIDDEN);
    localparam logic [CW-1:0] L0_N_LAST = CW'(N_HIDDEN - 1);
    localparam logic [CW-1:0] L1_N_LAST = CW'(N_OUTPUT - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(N_INPUTS - 1);
    localparam logic [14:0]   W1_LAST   = 15'(W1_SIZE - 1);
    localparam logic [14:0]   W2_LAST   = 15'(W2_SIZE - 1);
    localparam logic [31:0]   N_OUT_L   = 32'(N_OUTPUT);
    localparam logic signed [IN_WIDTH-1:0] ONE = IN_WIDTH'(1 << FRAC_BITS);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        L0_MAC = 4'd1,
        L0_ACT = 4'd2,
        L1_MAC = 4'd3,
        L1_ACT = 4'd4,
        DONE   = 4'd5
    } state_t;

    state_t state, state_next;

    logic signed [IN_WIDTH-1:0]  x_mem [N_INPUTS];
    logic signed [WGT_WIDTH-1:0] w1    [W1_SIZE];
    logic signed [WGT_WIDTH-1:0] w2    [W2_SIZE];
    logic signed [OUT_WIDTH-1:0] h     [N_HIDDEN];
    logic signed [OUT_WIDTH-1:0] y     [N_OUTPUT];

    logic signed [MAC_WIDTH-1:0] acc;
    logic [CW-1:0]  k, n, wptr;
    logic [31:0]    cyc_cnt, cycles;
    logic [XW-1:0]  in_ptr;
    logic           layer;
    logic [14:0]    widx;
    logic [31:0]    outsel;
    logic           done, irq_en, relu_hidden, relu_out;

    logic busy, wr_ctrl, run_req, cfg_wr;
    logic signed [IN_WIDTH-1:0]  a_op;
    logic signed [WGT_WIDTH-1:0] w_op;
    logic signed [PW-1:0]        prod;
    logic [31:0]                 rd_next;

    assign busy    = (state != IDLE);
    assign wr_ctrl = write_en && (addr == A_CTRL);
    assign run_req = wr_ctrl && writedata[0] && (state == IDLE);
    assign cfg_wr  = write_en && !busy;

    // Rescale by FRAC_BITS, apply optional ReLU, then fit into OUT_WIDTH.
    function automatic logic signed [OUT_WIDTH-1:0] act(input logic signed [MAC_WIDTH-1:0] a,
                                                        input logic relu);
        logic signed [MAC_WIDTH-1:0] s;
        s = a >>> FRAC_BITS;
        if (relu && s[MAC_WIDTH-1])
            s = '0;
`ifdef MLP_SEQ_SAT_EN
        begin
            logic signed [MAC_WIDTH-1:0] sat_hi;
            logic signed [MAC_WIDTH-1:0] sat_lo;
            sat_hi = MAC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
            sat_lo = ~sat_hi;
            if (s > sat_hi)
                s = sat_hi;
            else if (s < sat_lo)
                s = sat_lo;
        end
`endif
        return OUT_WIDTH'(s);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run_req) state_next = L0_MAC;
            L0_MAC:  if (k == L0_K_LAST) state_next = L0_ACT;
            L0_ACT:  state_next = (n == L0_N_LAST) ? L1_MAC : L0_MAC;
            L1_MAC:  if (k == L1_K_LAST) state_next = L1_ACT;
            L1_ACT:  state_next = (n == L1_N_LAST) ? DONE : L1_MAC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Column 0 of every row multiplies the implicit 1.0 bias input.
    always_comb begin
        a_op = '0;
        w_op = '0;
        if (state == L0_MAC) begin
            a_op = (k == '0) ? ONE : x_mem[XW'(k - 1'b1)];
            w_op = w1[W1_AW'(wptr)];
        end else if (state == L1_MAC) begin
            a_op = (k == '0) ? ONE : IN_WIDTH'(h[HW'(k - 1'b1)]);
            w_op = w2[W2_AW'(wptr)];
        end
        prod = a_op * w_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            k       <= '0;
            n       <= '0;
            wptr    <= '0;
            cyc_cnt <= '0;
            cycles  <= '0;
            for (int i = 0; i < N_HIDDEN; i++) h[i] <= '0;
            for (int i = 0; i < N_OUTPUT; i++) y[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_req) begin
                        acc     <= '0;
                        k       <= '0;
                        n       <= '0;
                        wptr    <= '0;
                        cyc_cnt <= '0;
                    end
                end
                L0_MAC, L1_MAC: begin
                    acc     <= acc + MAC_WIDTH'(prod);
                    k       <= k + 1'b1;
                    wptr    <= wptr + 1'b1;
                    cyc_cnt <= cyc_cnt + 32'd1;
                end
                L0_ACT: begin
                    h[HW'(n)] <= act(acc, relu_hidden);
                    acc       <= '0;
                    k         <= '0;
                    cyc_cnt   <= cyc_cnt + 32'd1;
                    if (n == L0_N_LAST) begin
                        n    <= '0;
                        wptr <= '0;
                    end else begin
                        n <= n + 1'b1;
                    end
                end
                L1_ACT: begin
                    y[YW'(n)] <= act(acc, relu_out);
                    acc       <= '0;
                    k         <= '0;
                    n         <= n + 1'b1;
                    cyc_cnt   <= cyc_cnt + 32'd1;
                end
                DONE:    cycles <= cyc_cnt + 32'd1;
                default: ;
            endcase
        end
    end

    // Done is sticky; a completing run outranks a simultaneous software clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            irq_en      <= 1'b0;
            relu_hidden <= 1'b0;
            relu_out    <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en      <= writedata[2];
                relu_hidden <= writedata[3];
                relu_out    <= writedata[4];
            end
            if (state == DONE)
                done <= 1'b1;
            else if (run_req || (wr_ctrl && writedata[1]))
                done <= 1'b0;
            irq <= irq_en & done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ptr <= '0;
            layer  <= 1'b0;
            widx   <= '0;
            outsel <= '0;
            for (int i = 0; i < N_INPUTS; i++) x_mem[i] <= '0;
            for (int i = 0; i < W1_SIZE; i++) w1[i] <= '0;
            for (int i = 0; i < W2_SIZE; i++) w2[i] <= '0;
        end else begin
            if (write_en && (addr == A_OUTSEL))
                outsel <= writedata;
            if (cfg_wr && (addr == A_INPUT)) begin
                x_mem[in_ptr] <= writedata[IN_WIDTH-1:0];
                in_ptr        <= (in_ptr == X_LAST) ? '0 : in_ptr + 1'b1;
            end
            if (cfg_wr && (addr == A_WADDR)) begin
                layer  <= writedata[15];
                widx   <= writedata[14:0];
                in_ptr <= '0;
            end
            if (cfg_wr && (addr == A_WDATA)) begin
                if (!layer) begin
                    if (widx <= W1_LAST) w1[W1_AW'(widx)] <= writedata[WGT_WIDTH-1:0];
                    widx <= (widx >= W1_LAST) ? '0 : widx + 1'b1;
                end else begin
                    if (widx <= W2_LAST) w2[W2_AW'(widx)] <= writedata[WGT_WIDTH-1:0];
                    widx <= (widx >= W2_LAST) ? '0 : widx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (addr)
            A_CTRL:   rd_next = {27'd0, relu_out, relu_hidden, irq_en, done, busy};
            A_WADDR:  rd_next = {16'd0, layer, widx};
            A_OUTSEL: rd_next = outsel;
            A_OUTPUT: if (outsel < N_OUT_L) rd_next = 32'(y[YW'(outsel)]);
            A_CYCLES: rd_next = cycles;
            A_STATUS: rd_next = {28'd0, state};
            default:  rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_mlp_seq.sv
// tb_mlp_seq: directed self-checking bench for mlp_seq with hand-computed expectations.
module tb_mlp_seq;

    logic        clk;
    logic        rst_n;
    logic        write_en;
    logic [2:0]  addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int checks;
    int errors;

    mlp_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write_en  (write_en),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        write_en  = 1'b1;
        addr      = a;
        writedata = d;
        @(negedge clk);
        write_en  = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        write_en = 1'b0;
        addr     = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic write_inputs(input logic [31:0] x0, input logic [31:0] x1);
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, x0);
        bus_write(3'd1, x1);
    endtask

    // Starts a run and returns the edge index (run-write edge = 0) at which done set.
    task automatic do_run(input logic [31:0] ctrl, output int done_cycle);
        done_cycle = -1;
        bus_write(3'd0, ctrl | 32'h1);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (readdata[1]) begin
                done_cycle = c - 1;
                break;
            end
        end
        checks++;
        if (done_cycle < 0) begin
            errors++;
            $display("[TB] FAIL run_timeout: done not seen within 100 cycles");
        end
        bus_write(3'd0, ctrl | 32'h2);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_readdata: got 0x%08h expected 0x00000000", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        rst_n = 1'b1;
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got 0x%08h expected 0x00000000", d);
        end
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_output: got 0x%08h expected 0x00000000", d);
        end
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_cycles: got 0x%08h expected 0x00000000", d);
        end
        bus_read(3'd7, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got 0x%08h expected 0x00000000", d);
        end
    endtask

    // x=(1.0,2.0), every hidden h=3.0, output = 1.0 + 4*3.0 = 13.0 = 3328.
    task automatic test_basic;
        logic [31:0] d;
        int dc;
        write_inputs(32'd256, 32'd512);
        bus_write(3'd2, 32'h0000);
        for (int r = 0; r < 4; r++) begin
            bus_write(3'd3, 32'd0);
            bus_write(3'd3, 32'd256);
            bus_write(3'd3, 32'd256);
        end
        bus_write(3'd2, 32'h8000);
        for (int i = 0; i < 5; i++) bus_write(3'd3, 32'd256);
        do_run(32'h0, dc);
        checks++;
        if (dc != 23) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d cycles expected 23", dc);
        end
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd3328) begin
            errors++;
            $display("[TB] FAIL basic_output: got %0d expected 3328", $signed(d));
        end
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'd23) begin
            errors++;
            $display("[TB] FAIL basic_cycles: got %0d expected 23", d);
        end
    endtask

    task automatic test_relu_hidden;
        logic [31:0] d;
        int dc;
        write_inputs(32'd256, 32'd0);
        bus_write(3'd2, 32'h0000);
        bus_write(3'd3, 32'd0);
        bus_write(3'd3, 32'hFFFF_FF00);
        for (int i = 0; i < 10; i++) bus_write(3'd3, 32'd0);
        bus_write(3'd2, 32'h8000);
        bus_write(3'd3, 32'd0);
        bus_write(3'd3, 32'd256);
        for (int i = 0; i < 3; i++) bus_write(3'd3, 32'd0);
        do_run(32'h8, dc);
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL relu_on_output: got 0x%08h expected 0x00000000", d);
        end
        do_run(32'h0, dc);
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'hFFFF_FF00) begin
            errors++;
            $display("[TB] FAIL relu_off_output: got 0x%08h expected 0xffffff00", d);
        end
    endtask

    // 2*32767*32767 >>> 8 = 0x7FFE00: wraps to -512 or saturates to 32767.
    task automatic test_saturation;
        logic [31:0] d;
        logic [31:0] exp_out;
        int dc;
`ifdef MLP_SEQ_SAT_EN
        exp_out = 32'd32767;
`else
        exp_out = 32'hFFFF_FE00;
`endif
        write_inputs(32'd32767, 32'd32767);
        bus_write(3'd2, 32'h0000);
        bus_write(3'd3, 32'd0);
        bus_write(3'd3, 32'd32767);
        bus_write(3'd3, 32'd32767);
        for (int i = 0; i < 9; i++) bus_write(3'd3, 32'd0);
        do_run(32'h0, dc);
        bus_read(3'd5, d);
        checks++;
        if (d !== exp_out) begin
            errors++;
            $display("[TB] FAIL sat_output: got 0x%08h expected 0x%08h", d, exp_out);
        end
    endtask

    // With x=0 each h equals its bias; W2=(0,256,0,0,0) makes OUTPUT = W1[0][0].
    task automatic test_weight_wrap;
        logic [31:0] d;
        int dc;
        write_inputs(32'd0, 32'd0);
        bus_write(3'd2, 32'h0000);
        bus_write(3'd3, 32'd256);
        for (int i = 0; i < 11; i++) bus_write(3'd3, 32'd0);
        bus_write(3'd3, 32'd1280);
        do_run(32'h0, dc);
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd1280) begin
            errors++;
            $display("[TB] FAIL wrap_output: got %0d expected 1280", $signed(d));
        end
    endtask

    task automatic test_irq_busy;
        logic [31:0] d;
        logic irq23;
        logic irq24;
        write_inputs(32'd256, 32'd512);
        bus_write(3'd2, 32'h0000);
        for (int r = 0; r < 4; r++) begin
            bus_write(3'd3, 32'd0);
            bus_write(3'd3, 32'd256);
            bus_write(3'd3, 32'd256);
        end
        bus_write(3'd2, 32'h8000);
        for (int i = 0; i < 5; i++) bus_write(3'd3, 32'd256);
        irq23 = 1'bx;
        irq24 = 1'bx;
        bus_write(3'd0, 32'h5);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 23) irq23 = irq;
            if (c == 24) irq24 = irq;
            if (c == 5) begin
                write_en  = 1'b1;
                addr      = 3'd1;
                writedata = 32'h4000;
            end
            if (c == 6) begin
                write_en = 1'b0;
                addr     = 3'd0;
            end
        end
        checks++;
        if (irq23 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_cycle23: got %b expected 0", irq23);
        end
        checks++;
        if (irq24 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_cycle24: got %b expected 1", irq24);
        end
        bus_write(3'd0, 32'h6);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_clear_edge: got %b expected 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_after_clear: got %b expected 0", irq);
        end
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("[TB] FAIL irq_ctrl_after_clear: got 0x%08h expected 0x00000004", d);
        end
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd3328) begin
            errors++;
            $display("[TB] FAIL busy_input_ignored: got %0d expected 3328", $signed(d));
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] d;
        bus_write(3'd0, 32'h1);
        addr = 3'd7;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_readdata: got 0x%08h expected 0x00000000", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_irq: got %b expected 0", irq);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(3'd7, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_status: got 0x%08h expected 0x00000000", d);
        end
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_output: got 0x%08h expected 0x00000000", d);
        end
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl: got 0x%08h expected 0x00000000", d);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        write_en  = 1'b0;
        addr      = 3'd0;
        writedata = 32'd0;
        test_reset;
        test_basic;
        test_relu_hidden;
        test_saturation;
        test_weight_wrap;
        test_irq_busy;
        test_reset_mid_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
